// File: rtl/lc3_ctrl_pkg.sv
// Shared LC-3 control encodings: opcodes, datapath mux selects and the
// branch-sequencer state enum.
package lc3_ctrl_pkg;

    localparam logic [3:0] OP_BR  = 4'b0000;
    localparam logic [3:0] OP_JSR = 4'b0100;
    localparam logic [3:0] OP_JMP = 4'b1100;

    localparam logic [1:0] PCMUX_PC_INC = 2'd0;
    localparam logic [1:0] PCMUX_BUS    = 2'd1;
    localparam logic [1:0] PCMUX_ADDER  = 2'd2;

    localparam logic       ADDR1_PC     = 1'b0;
    localparam logic       ADDR1_BASER  = 1'b1;

    localparam logic [1:0] ADDR2_ZERO   = 2'd0;
    localparam logic [1:0] ADDR2_OFF6   = 2'd1;
    localparam logic [1:0] ADDR2_OFF9   = 2'd2;
    localparam logic [1:0] ADDR2_OFF11  = 2'd3;

    localparam logic [1:0] DR_IR11_9    = 2'd0;
    localparam logic [1:0] DR_R7        = 2'd1;
    localparam logic [1:0] DR_IR8_6     = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BR_EVAL,
        ST_BR_TEST,
        ST_BR_TAKE,
        ST_JMP_GO,
        ST_JSR_GO,
        ST_BAD
    } br_state_e;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; synchronous
// active-low clear.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q = cnt_q;

endmodule

// File: rtl/lc3_branch_seq.sv
// Sequencer for BR / JMP / JSR(R): evaluates BEN, issues the PC and link
// loads for one instruction and returns to the main FSM with a done pulse.
module lc3_branch_seq
    import lc3_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       opcode,
    input  logic             ir11,
    input  logic             ben,
    output logic             busy,
    output logic             done,
    output logic             ld_ben,
    output logic             ld_pc,
    output logic [1:0]       pcmux,
    output logic             addr1mux,
    output logic [1:0]       addr2mux,
    output logic             ld_reg,
    output logic [1:0]       drmux,
    output logic             gate_pc,
    output logic [CNT_W-1:0] taken_cnt,
    output logic [CNT_W-1:0] ntaken_cnt
);

    br_state_e state_q;
    br_state_e state_d;
    logic      ir11_q;
    logic      ir11_d;
    logic      inc_taken;
    logic      inc_ntaken;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ir11_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ir11_q  <= ir11_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ir11_d  = ir11_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    case (opcode)
                        OP_BR:   state_d = ST_BR_EVAL;
                        OP_JMP:  state_d = ST_JMP_GO;
                        OP_JSR: begin
                            state_d = ST_JSR_GO;
                            ir11_d  = ir11;
                        end
                        default: state_d = ST_BAD;
                    endcase
                end
            end
            ST_BR_EVAL: state_d = ST_BR_TEST;
            ST_BR_TEST: state_d = ben ? ST_BR_TAKE : ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        done       = 1'b0;
        ld_ben     = 1'b0;
        ld_pc      = 1'b0;
        pcmux      = PCMUX_PC_INC;
        addr1mux   = ADDR1_PC;
        addr2mux   = ADDR2_ZERO;
        ld_reg     = 1'b0;
        drmux      = DR_IR11_9;
        gate_pc    = 1'b0;
        inc_taken  = 1'b0;
        inc_ntaken = 1'b0;
        case (state_q)
            ST_BR_EVAL: ld_ben = 1'b1;
            ST_BR_TEST: begin
                done       = ~ben;
                inc_ntaken = ~ben;
            end
            ST_BR_TAKE: begin
                ld_pc     = 1'b1;
                pcmux     = PCMUX_ADDER;
                addr1mux  = ADDR1_PC;
                addr2mux  = ADDR2_OFF9;
                done      = 1'b1;
                inc_taken = 1'b1;
            end
            ST_JMP_GO: begin
                ld_pc    = 1'b1;
                pcmux    = PCMUX_ADDER;
                addr1mux = ADDR1_BASER;
                addr2mux = ADDR2_ZERO;
                done     = 1'b1;
            end
            ST_JSR_GO: begin
                // Link and jump share one edge; R7 gets the pre-edge PC even for JSRR R7.
                gate_pc  = 1'b1;
                ld_reg   = 1'b1;
                drmux    = DR_R7;
                ld_pc    = 1'b1;
                pcmux    = PCMUX_ADDER;
                addr1mux = ir11_q ? ADDR1_PC : ADDR1_BASER;
                addr2mux = ir11_q ? ADDR2_OFF11 : ADDR2_ZERO;
                done     = 1'b1;
            end
            ST_BAD:  done = 1'b1;
            default: ;
        endcase
    end

    assign busy = (state_q != ST_IDLE);

    sat_counter #(.W(CNT_W)) u_taken_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (inc_taken),
        .q     (taken_cnt)
    );

    sat_counter #(.W(CNT_W)) u_ntaken_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (inc_ntaken),
        .q     (ntaken_cnt)
    );

endmodule

// File: tb/tb_lc3_branch_seq.sv
// Scoreboard bench for lc3_branch_seq: expected done-cycle controls are queued
// at start and popped when done is seen.
module tb_lc3_branch_seq;
    import lc3_ctrl_pkg::*;

    localparam int CNT_W = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [3:0]       opcode = 4'h0;
    logic             ir11 = 1'b0;
    logic             ben = 1'b0;
    logic             busy, done, ld_ben, ld_pc, addr1mux, ld_reg, gate_pc;
    logic [1:0]       pcmux, addr2mux, drmux;
    logic [CNT_W-1:0] taken_cnt, ntaken_cnt;

    typedef struct {
        int         lat;
        logic       ld_pc;
        logic [1:0] pcmux;
        logic       a1;
        logic [1:0] a2;
        logic       ld_reg;
        logic [1:0] dr;
        logic       gpc;
        int         tk;
        int         ntk;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   model_tk = 0;
    int   model_ntk = 0;

    lc3_branch_seq #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .opcode     (opcode),
        .ir11       (ir11),
        .ben        (ben),
        .busy       (busy),
        .done       (done),
        .ld_ben     (ld_ben),
        .ld_pc      (ld_pc),
        .pcmux      (pcmux),
        .addr1mux   (addr1mux),
        .addr2mux   (addr2mux),
        .ld_reg     (ld_reg),
        .drmux      (drmux),
        .gate_pc    (gate_pc),
        .taken_cnt  (taken_cnt),
        .ntaken_cnt (ntaken_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_loads"}, {29'd0, ld_ben, ld_pc, ld_reg}, 32'd0);
        chk({tag, "_gate_pc"}, {31'd0, gate_pc}, 32'd0);
    endtask

    function automatic exp_t predict(input logic [3:0] op, input logic i11, input logic b);
        exp_t e;
        e = '{lat: 1, ld_pc: 1'b0, pcmux: 2'd0, a1: 1'b0, a2: 2'd0, ld_reg: 1'b0,
              dr: 2'd0, gpc: 1'b0, tk: 0, ntk: 0};
        case (op)
            4'b0000: begin
                if (b) begin
                    e.lat = 3; e.ld_pc = 1'b1; e.pcmux = PCMUX_ADDER;
                    e.a1 = ADDR1_PC; e.a2 = ADDR2_OFF9;
                    if (model_tk < CNT_MAX) model_tk++;
                end else begin
                    e.lat = 2;
                    if (model_ntk < CNT_MAX) model_ntk++;
                end
            end
            4'b1100: begin
                e.ld_pc = 1'b1; e.pcmux = PCMUX_ADDER; e.a1 = ADDR1_BASER; e.a2 = ADDR2_ZERO;
            end
            4'b0100: begin
                e.ld_pc = 1'b1; e.pcmux = PCMUX_ADDER; e.ld_reg = 1'b1; e.dr = DR_R7; e.gpc = 1'b1;
                e.a1 = i11 ? ADDR1_PC : ADDR1_BASER;
                e.a2 = i11 ? ADDR2_OFF11 : ADDR2_ZERO;
            end
            default: ;
        endcase
        e.tk = model_tk;
        e.ntk = model_ntk;
        return e;
    endfunction

    // restart=1 re-pulses start during the first busy cycle; it must be ignored.
    task automatic run_op(input string tag, input logic [3:0] op, input logic i11,
                          input logic b, input bit restart);
        exp_t e;
        bit   seen;
        exp_q.push_back(predict(op, i11, b));
        seen = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; opcode = op; ir11 = i11; ben = b;
        @(posedge clk); #1;
        start = restart;
        if (restart) begin
            opcode = 4'b1100; ir11 = ~i11;
        end
        for (int cyc = 1; cyc <= 6; cyc++) begin
            @(negedge clk);
            chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
            if (op == 4'b0000 && cyc == 1) chk({tag, "_ld_ben"}, {31'd0, ld_ben}, 32'd1);
            if (done) begin
                seen = 1'b1;
                e = exp_q.pop_front();
                chk({tag, "_latency"}, cyc, e.lat);
                chk({tag, "_ld_pc"}, {31'd0, ld_pc}, {31'd0, e.ld_pc});
                chk({tag, "_pcmux"}, {30'd0, pcmux}, {30'd0, e.pcmux});
                chk({tag, "_addr1mux"}, {31'd0, addr1mux}, {31'd0, e.a1});
                chk({tag, "_addr2mux"}, {30'd0, addr2mux}, {30'd0, e.a2});
                chk({tag, "_ld_reg"}, {31'd0, ld_reg}, {31'd0, e.ld_reg});
                chk({tag, "_drmux"}, {30'd0, drmux}, {30'd0, e.dr});
                chk({tag, "_gate_pc"}, {31'd0, gate_pc}, {31'd0, e.gpc});
                break;
            end
            chk({tag, "_early_ld_pc"}, {31'd0, ld_pc}, 32'd0);
            @(posedge clk); #1;
            start = 1'b0;
        end
        if (!seen) begin
            chk({tag, "_done_timeout"}, 32'd0, 32'd1);
            void'(exp_q.pop_front());
        end
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check_idle({tag, "_after"});
        chk({tag, "_taken_cnt"}, {28'd0, taken_cnt}, e.tk);
        chk({tag, "_ntaken_cnt"}, {28'd0, ntaken_cnt}, e.ntk);
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle("reset");
        chk("reset_taken", {28'd0, taken_cnt}, 32'd0);
        chk("reset_ntaken", {28'd0, ntaken_cnt}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        run_op("br_taken", 4'b0000, 1'b0, 1'b1, 1'b0);
        run_op("br_ntaken", 4'b0000, 1'b1, 1'b0, 1'b0);
        run_op("jsrr", 4'b0100, 1'b0, 1'b0, 1'b0);
        run_op("jsr", 4'b0100, 1'b1, 1'b1, 1'b0);
        run_op("jmp", 4'b1100, 1'b1, 1'b0, 1'b0);
        run_op("br_restart", 4'b0000, 1'b0, 1'b1, 1'b1);
        run_op("jsr_restart", 4'b0100, 1'b1, 1'b0, 1'b1);
        run_op("bad_0001", 4'b0001, 1'b0, 1'b1, 1'b0);
        run_op("bad_1111", 4'b1111, 1'b1, 1'b1, 1'b0);

        // Reset asserted while sitting in BR_TEST with a taken branch pending.
        @(posedge clk); #1;
        start = 1'b1; opcode = 4'b0000; ben = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_test_busy", {31'd0, busy}, 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_tk = 0;
        model_ntk = 0;
        @(negedge clk);
        check_idle("midrst_c1");
        chk("midrst_taken", {28'd0, taken_cnt}, 32'd0);
        chk("midrst_ntaken", {28'd0, ntaken_cnt}, 32'd0);
        @(negedge clk);
        check_idle("midrst_c2");

        run_op("br_ntaken2", 4'b0000, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 17; i++) begin
            run_op($sformatf("sat_%0d", i), 4'b0000, 1'b0, 1'b1, 1'b0);
        end
        chk("sat_final", {28'd0, taken_cnt}, 32'hF);
        chk("scoreboard_empty", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
